bayer_stream_gen: RTL
=====================

# bayer_stream_gen

Synthesizable raw-Bayer pixel source that drives the camera-side capture interface consumed by `image_proc`: `X_Cont`, `Y_Cont`, 12-bit `DATA` and `DVAL`. It produces framed traffic with line and frame blanking, selectable test patterns and optional stalls. It replaces the CCD capture block for on-board bring-up, and acts as the stimulus engine for `image_proc` benches.

## Interface
- `H_ACTIVE`, default 1280: valid pixels per line (≤ 2047).
- `V_ACTIVE`, default 960: active lines per frame (≤ 2047).
- `H_BLANK`, default 16: idle cycles between active lines (≥ 1).
- `V_BLANK`, default 4: idle cycles after the last line of a frame (≥ 1).
- `SEED`, default 16'hACE1: LFSR seed (nonzero).

Ports:
- `iCLK`  in  1  clock; single domain.
- `iRST`  in  1  synchronous, active-high reset.
- `iStart`  in  1  start-frame request; accepted only in IDLE.
- `iCont`  in  1  continuous mode; sampled at the end of each frame.
- `iMode`  in  2  pattern select; latched when a frame starts.
- `iPause`  in  1  stall request; honoured only during active pixels.
- `oX_Cont`  out  11  pixel column; 0 when `oDVAL`=0.
- `oY_Cont`  out  11  line index of the current or most recent active line; 0 in IDLE.
- `oDATA`  out  12  raw pixel; 0 when `oDVAL`=0.
- `oDVAL`  out  1  pixel valid.
- `oFVAL`  out  1  frame valid; high from the first pixel through the last pixel.
- `oBusy`  out  1  high whenever the state is not IDLE.
- `oFrameDone`  out  1  one-cycle pulse at frame completion.

## Operation
- States:
  - IDLE → ACTIVE on `iStart`.
  - ACTIVE → HBLANK after pixel `H_ACTIVE`-1 on any line except the last.
  - ACTIVE → VBLANK after the last pixel of line `V_ACTIVE`-1.
  - HBLANK → ACTIVE after `H_BLANK` cycles, with Y+1 and X=0.
  - VBLANK → ACTIVE (frame restart) if `iCont`=1 at the last VBLANK cycle; otherwise VBLANK → IDLE.
- Frame start, on `iStart` in IDLE or on a continuous restart:
  - latch `iMode`;
  - reload the LFSR with `SEED`;
  - X=Y=0.
- Patterns, evaluated on the current X/Y:
  - `00` LFSR: 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, shifting left, feedback into bit 0. DATA = LFSR[11:0]. The LFSR advances once per emitted pixel only.
  - `01` horizontal ramp: DATA = {X, 1'b0}, 12 bits, no overflow for X ≤ 2047.
  - `10` vertical ramp: DATA = {Y, 1'b0}.
  - `11` checkerboard: DATA = (X[4]^Y[4]) ? 12'hFFF : 12'h000.
- `iPause`=1 in ACTIVE:
  - the next cycle shows `oDVAL`=0 and `oDATA`=0;
  - X, Y and the LFSR hold;
  - `oFVAL` stays 1;
  - the pixel is emitted once pause drops.
- `iPause` has no effect in HBLANK, VBLANK or IDLE.
- `iStart` while `oBusy`=1 is ignored.
- `iMode` changes mid-frame take effect only at the next frame start.
- `iRST` (any state, including mid-frame):
  - state returns to IDLE;
  - all outputs go to 0 on the next edge;
  - LFSR = `SEED`;
  - `iRST` has priority over `iStart`.

## Timing
- All outputs are registered. Reset value of every output is 0.
- `iStart` sampled high in IDLE at edge k → at edge k+1: `oDVAL`=1, `oFVAL`=1, `oBusy`=1, X=0, Y=0, first pattern pixel.
- Cycles per frame with no pauses: V_ACTIVE·H_ACTIVE + (V_ACTIVE−1)·H_BLANK + V_BLANK.
- `oFVAL` drops on the first VBLANK cycle.
- `oFrameDone` is high for exactly the one cycle following the last VBLANK cycle:
  - single mode: that cycle is IDLE, with `oBusy`=0;
  - continuous mode: that cycle carries pixel (0,0) of the next frame, with `oDVAL`=1, so frames run back-to-back with no extra gap.
- A new `iStart` is accepted in the same cycle as `oFrameDone` (single mode) and gives a first pixel one cycle later.
- Each pause cycle extends the frame by one cycle.

## Test plan
- Small frame, H_ACTIVE=8, V_ACTIVE=4, H_BLANK=2, V_BLANK=3, mode `01`, one `iStart` pulse:
  - 32 `oDVAL` cycles, DATA 0,2,…,14 per line;
  - `oFrameDone` exactly 41 cycles after the first pixel;
  - `oBusy` 0 afterwards.
- Mode `00`, same frame, two single frames:
  - first pixel = 12'hCE1, i.e. SEED[11:0];
  - both frames produce an identical 32-word sequence (reseed check).
- Mode `11`, H_ACTIVE=32, V_ACTIVE=32: DATA is 0 for X,Y<16; 12'hFFF for X≥16,Y<16; 0 for X≥16,Y≥16.
- `iPause` held 5 cycles at pixel X=3 in mode `01`:
  - five `oDVAL`=0 cycles with X held at 3;
  - DATA 6 then resumes;
  - frame is 5 cycles longer.
- `iCont`=1:
  - pixel (0,0) appears in the `oFrameDone` cycle;
  - `iStart` pulses mid-frame are ignored;
  - an `iMode` change applies at the next frame only.
- `iRST` asserted mid-line at X=5, Y=2: next cycle all outputs are 0 and `oBusy`=0; a later `iStart` restarts at (0,0) with the LFSR at SEED.

Source files
------------

// File: rtl/bayer_stream_gen.sv
// bayer_stream_gen: framed raw-Bayer test-pattern source
// Drives X/Y/DATA/DVAL capture traffic with blanking, stalls and patterns.
module bayer_stream_gen #(
    parameter int          H_ACTIVE = 1280,
    parameter int          V_ACTIVE = 960,
    parameter int          H_BLANK  = 16,
    parameter int          V_BLANK  = 4,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iStart,
    input  logic        iCont,
    input  logic [1:0]  iMode,
    input  logic        iPause,
    output logic [10:0] oX_Cont,
    output logic [10:0] oY_Cont,
    output logic [11:0] oDATA,
    output logic        oDVAL,
    output logic        oFVAL,
    output logic        oBusy,
    output logic        oFrameDone
);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        HBLANK,
        VBLANK
    } state_t;

    localparam logic [10:0] X_LAST  = 11'(H_ACTIVE - 1);
    localparam logic [10:0] Y_LAST  = 11'(V_ACTIVE - 1);
    localparam logic [15:0] HB_LAST = 16'(H_BLANK - 1);
    localparam logic [15:0] VB_LAST = 16'(V_BLANK - 1);

    state_t      state, state_n;
    logic [10:0] x, x_n;
    logic [10:0] y, y_n;
    logic [15:0] cnt, cnt_n;
    logic [15:0] lfsr, lfsr_n;
    logic [1:0]  mode, mode_n;
    logic        dval_n;
    logic        fval_n;
    logic        done_n;
    logic [11:0] pat;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Next state, position, LFSR and pixel-valid for the cycle after this edge
    always_comb begin
        state_n = state;
        x_n     = x;
        y_n     = y;
        cnt_n   = cnt;
        lfsr_n  = lfsr;
        mode_n  = mode;
        dval_n  = 1'b0;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (iStart) begin
                    state_n = ACTIVE;
                    x_n     = '0;
                    y_n     = '0;
                    lfsr_n  = SEED;
                    mode_n  = iMode;
                    dval_n  = 1'b1;
                end
            end
            ACTIVE: begin
                if (oDVAL) begin
                    lfsr_n = lfsr_step(lfsr);
                    if (x == X_LAST) begin
                        cnt_n   = '0;
                        state_n = (y == Y_LAST) ? VBLANK : HBLANK;
                    end else begin
                        x_n    = x + 11'd1;
                        dval_n = !iPause;
                    end
                end else begin
                    dval_n = !iPause;
                end
            end
            HBLANK: begin
                if (cnt == HB_LAST) begin
                    state_n = ACTIVE;
                    x_n     = '0;
                    y_n     = y + 11'd1;
                    dval_n  = 1'b1;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            VBLANK: begin
                if (cnt == VB_LAST) begin
                    done_n = 1'b1;
                    x_n    = '0;
                    y_n    = '0;
                    if (iCont) begin
                        state_n = ACTIVE;
                        lfsr_n  = SEED;
                        mode_n  = iMode;
                        dval_n  = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase
        fval_n = (state_n == ACTIVE) || (state_n == HBLANK);
    end

    // Pattern value for the pixel about to be presented
    always_comb begin
        pat = '0;
        unique case (mode_n)
            2'b00: pat = lfsr_n[11:0];
            2'b01: pat = {x_n, 1'b0};
            2'b10: pat = {y_n, 1'b0};
            2'b11: pat = (x_n[4] ^ y_n[4]) ? 12'hFFF : 12'h000;
            default: pat = '0;
        endcase
    end

    // State, counters and fully registered outputs
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            cnt        <= '0;
            lfsr       <= SEED;
            mode       <= '0;
            oX_Cont    <= '0;
            oY_Cont    <= '0;
            oDATA      <= '0;
            oDVAL      <= 1'b0;
            oFVAL      <= 1'b0;
            oBusy      <= 1'b0;
            oFrameDone <= 1'b0;
        end else begin
            state      <= state_n;
            x          <= x_n;
            y          <= y_n;
            cnt        <= cnt_n;
            lfsr       <= lfsr_n;
            mode       <= mode_n;
            oX_Cont    <= dval_n ? x_n : 11'd0;
            oY_Cont    <= y_n;
            oDATA      <= dval_n ? pat : 12'd0;
            oDVAL      <= dval_n;
            oFVAL      <= fval_n;
            oBusy      <= (state_n != IDLE);
            oFrameDone <= done_n;
        end
    end

endmodule
